// File: rtl/udma_mdio_pkg.sv
// Shared types and frame constants for the uDMA MDIO (Clause 22 / Clause 45) master.
// Holds the FSM state encoding, start/opcode/turnaround patterns and frame field sizes.
package udma_mdio_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    HEADER   = 3'd2,
    TA       = 3'd3,
    DATA     = 3'd4,
    DONE     = 3'd5
  } mdio_state_e;

  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  localparam logic [1:0] OP_C22_WRITE    = 2'b01;
  localparam logic [1:0] OP_C22_READ     = 2'b10;
  localparam logic [1:0] OP_C45_ADDR     = 2'b00;
  localparam logic [1:0] OP_C45_WRITE    = 2'b01;
  localparam logic [1:0] OP_C45_READ     = 2'b11;
  localparam logic [1:0] OP_C45_READ_INC = 2'b10;

  // Turnaround driven by the master on write/address frames, MSB first.
  localparam logic [1:0] TA_WRITE = 2'b10;

  localparam logic [4:0] HDR_LAST  = 5'd13;
  localparam logic [4:0] TA_LAST   = 5'd1;
  localparam logic [4:0] DATA_LAST = 5'd15;

  // Anything not decoded as a read (including illegal C22 opcodes) is sent as a write.
  function automatic logic is_read_op(input logic c45, input logic [1:0] op);
    if (c45) return (op == OP_C45_READ) || (op == OP_C45_READ_INC);
    return op == OP_C22_READ;
  endfunction

endpackage

// File: rtl/udma_mdio_clkgen.sv
// MDC generator: D cycles low then D cycles high per frame bit, held at 0 while disabled.
// rise_tick_o marks the first high cycle (sample point), fall_tick_o the last high cycle (bit end).
module udma_mdio_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             mdc_o,
  output logic             fall_tick_o,
  output logic             rise_tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             mdc_q, mdc_d;
  logic             cnt_last;

  assign cnt_last = (cnt_q == (div_i - DIV_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (!en_i) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (cnt_last) begin
      cnt_d = '0;
      mdc_d = ~mdc_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

  assign mdc_o       = mdc_q;
  assign rise_tick_o = en_i & mdc_q & (cnt_q == '0);
  assign fall_tick_o = en_i & mdc_q & cnt_last;

endmodule

// File: rtl/udma_mdio_master.sv
// MDIO management master: serialises one Clause 22 or Clause 45 frame per accepted request.
// Request handshake: start_i is taken only while busy_o=0; busy_o then stays high through done_o.
module udma_mdio_master
  import udma_mdio_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int PRE_LEN = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [DIV_W-1:0] clk_div_i,
  input  logic             start_i,
  input  logic             c45_i,
  input  logic [1:0]       op_i,
  input  logic             pre_en_i,
  input  logic [4:0]       phy_addr_i,
  input  logic [4:0]       reg_addr_i,
  input  logic [15:0]      wr_data_i,
  input  logic             mdi_i,
  output logic             mdo_o,
  output logic             md_oen_o,
  output logic             mdc_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      rd_data_o,
  output logic             ack_err_o,
  output logic [2:0]       dbg_state_o
);

  localparam logic [4:0] PRE_LAST = 5'(PRE_LEN - 1);

  mdio_state_e      state_q, state_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [13:0]      hdr_q;
  logic [15:0]      wr_data_q;
  logic             is_rd_q;
  logic [DIV_W-1:0] div_q;
  logic [15:0]      rd_shift_q;
  logic             ta_ack_q;
  logic [15:0]      rd_data_q;
  logic             ack_err_q;

  logic             accept;
  logic             run;
  logic             fall_tick;
  logic             rise_tick;
  logic [DIV_W-1:0] div_eff;

  assign accept  = (state_q == IDLE) && start_i;
  assign run     = (state_q == PREAMBLE) || (state_q == HEADER) ||
                   (state_q == TA) || (state_q == DATA);
  assign div_eff = (clk_div_i < DIV_W'(2)) ? DIV_W'(2) : clk_div_i;

  udma_mdio_clkgen #(
    .DIV_W(DIV_W)
  ) u_clkgen (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_i       (run),
    .div_i      (div_q),
    .mdc_o      (mdc_o),
    .fall_tick_o(fall_tick),
    .rise_tick_o(rise_tick)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Every frame field advances at the end of an MDC high phase.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = pre_en_i ? PREAMBLE : HEADER;
          bit_cnt_d = '0;
        end
      end
      PREAMBLE: begin
        if (fall_tick) begin
          if (bit_cnt_q == PRE_LAST) begin
            state_d   = HEADER;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      HEADER: begin
        if (fall_tick) begin
          if (bit_cnt_q == HDR_LAST) begin
            state_d   = TA;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      TA: begin
        if (fall_tick) begin
          if (bit_cnt_q == TA_LAST) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (fall_tick) begin
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = DONE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from registered state, so they move only at the start of a low phase.
  always_comb begin
    mdo_o    = 1'b1;
    md_oen_o = 1'b0;
    done_o   = 1'b0;
    busy_o   = (state_q != IDLE);
    case (state_q)
      PREAMBLE: md_oen_o = 1'b1;
      HEADER: begin
        md_oen_o = 1'b1;
        mdo_o    = hdr_q[4'd13 - bit_cnt_q[3:0]];
      end
      TA: begin
        if (!is_rd_q) begin
          md_oen_o = 1'b1;
          mdo_o    = bit_cnt_q[0] ? TA_WRITE[0] : TA_WRITE[1];
        end
      end
      DATA: begin
        if (!is_rd_q) begin
          md_oen_o = 1'b1;
          mdo_o    = wr_data_q[4'd15 - bit_cnt_q[3:0]];
        end
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hdr_q      <= '0;
      wr_data_q  <= '0;
      is_rd_q    <= 1'b0;
      div_q      <= DIV_W'(2);
      rd_shift_q <= '0;
      ta_ack_q   <= 1'b0;
      rd_data_q  <= '0;
      ack_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        hdr_q     <= {(c45_i ? ST_C45 : ST_C22), op_i, phy_addr_i, reg_addr_i};
        wr_data_q <= wr_data_i;
        is_rd_q   <= is_read_op(c45_i, op_i);
        div_q     <= div_eff;
      end
      // A PHY that answers pulls the second turnaround bit low.
      if ((state_q == TA) && rise_tick && bit_cnt_q[0]) ta_ack_q <= mdi_i;
      if ((state_q == DATA) && rise_tick) rd_shift_q <= {rd_shift_q[14:0], mdi_i};
      if ((state_q == DONE) && is_rd_q) begin
        rd_data_q <= rd_shift_q;
        ack_err_q <= ta_ack_q;
      end
    end
  end

  assign rd_data_o   = rd_data_q;
  assign ack_err_o   = ack_err_q;
  assign dbg_state_o = state_q;

endmodule
